// File: rtl/cayde_alu_pkg.sv
// Shared types for the cayde ALU: op encodings, executor states and op classifiers.
// Also imported by the ALU controller, which produces the alu_op_e codes.
package cayde_alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_SUB  = 4'b0100,
      OP_SLT  = 4'b0101,
      OP_SLTU = 4'b0110,
      OP_SLL  = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } exec_state_e;

   function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
      return (op <= OP_SRA);
   endfunction

   function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/cayde_alu_if.sv
// Request/response bundle between decode, the ALU executor and writeback.
// master drives requests and accepts results; slave is the executor.
interface cayde_alu_if
   import cayde_alu_pkg::*;
#(
   parameter int XLEN = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [ALU_OP_W-1:0] op;
   logic [XLEN-1:0]     a;
   logic [XLEN-1:0]     b;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     result;
   logic                zero;
   logic                illegal;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );

endinterface

// File: rtl/cayde_alu_shift_step.sv
// Combinational one-bit shift of the working value for SLL (0 fill),
// SRL (0 fill) and SRA (sign fill); one step per SHIFT-state cycle.
module cayde_alu_shift_step
   import cayde_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_op_e         op,
   input  logic [XLEN-1:0] work,
   output logic [XLEN-1:0] work_shifted
);
   logic is_sll;
   logic msb_fill;

   assign is_sll   = (op == OP_SLL);
   assign msb_fill = (op == OP_SRA) ? work[XLEN-1] : 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < XLEN; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign work_shifted[gi] = is_sll ? 1'b0 : work[gi+1];
         end else if (gi == XLEN-1) begin : g_msb
            assign work_shifted[gi] = is_sll ? work[gi-1] : msb_fill;
         end else begin : g_mid
            assign work_shifted[gi] = is_sll ? work[gi-1] : work[gi+1];
         end
      end
   endgenerate

endmodule

// File: rtl/cayde_alu_exec.sv
// ALU executor: single-cycle logic/arith ops, iterative 1-bit-per-cycle shifts.
// Define CAYDE_ALU_BARREL_EN to replace the shift loop with a one-cycle barrel shifter.
module cayde_alu_exec
   import cayde_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   cayde_alu_if.slave     bus
);
   localparam int SH_W = $clog2(XLEN);

   exec_state_e     state_reg, state_next;
   logic [XLEN-1:0] result_reg, result_next;
   logic            zero_reg, zero_next;
   logic            illegal_reg, illegal_next;
   logic [XLEN-1:0] alu_res;
   logic [SH_W-1:0] shamt;
   logic            lt_signed;
   logic            lt_unsigned;

   assign shamt       = bus.b[SH_W-1:0];
   assign lt_signed   = ($signed(bus.a) < $signed(bus.b));
   assign lt_unsigned = (bus.a < bus.b);

`ifndef CAYDE_ALU_BARREL_EN
   logic [XLEN-1:0] work_reg, work_next;
   logic [XLEN-1:0] work_shifted;
   logic [SH_W-1:0] cnt_reg, cnt_next;
   alu_op_e         sop_reg, sop_next;

   cayde_alu_shift_step #(
      .XLEN (XLEN)
   ) u_shift_step (
      .op           (sop_reg),
      .work         (work_reg),
      .work_shifted (work_shifted)
   );
`endif

   always_comb begin
      alu_res = '0;
      case (bus.op)
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_signed};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_unsigned};
`ifdef CAYDE_ALU_BARREL_EN
         OP_SLL:  alu_res = bus.a << shamt;
         OP_SRL:  alu_res = bus.a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
`else
         // Only reached with shamt==0; nonzero amounts go through SHIFT.
         OP_SLL, OP_SRL, OP_SRA: alu_res = bus.a;
`endif
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      result_next  = result_reg;
      zero_next    = zero_reg;
      illegal_next = illegal_reg;
`ifndef CAYDE_ALU_BARREL_EN
      work_next    = work_reg;
      cnt_next     = cnt_reg;
      sop_next     = sop_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               state_next = DONE;
               if (!is_legal_op(bus.op)) begin
                  result_next  = '0;
                  zero_next    = 1'b1;
                  illegal_next = 1'b1;
               end
`ifndef CAYDE_ALU_BARREL_EN
               else if (is_shift_op(bus.op) && (shamt != '0)) begin
                  state_next   = SHIFT;
                  work_next    = bus.a;
                  cnt_next     = shamt;
                  sop_next     = alu_op_e'(bus.op);
                  illegal_next = 1'b0;
               end
`endif
               else begin
                  result_next  = alu_res;
                  zero_next    = (alu_res == '0);
                  illegal_next = 1'b0;
               end
            end
         end
`ifndef CAYDE_ALU_BARREL_EN
         SHIFT: begin
            work_next = work_shifted;
            cnt_next  = cnt_reg - SH_W'(1);
            if (cnt_reg == SH_W'(1)) begin
               result_next = work_shifted;
               zero_next   = (work_shifted == '0);
               state_next  = DONE;
            end
         end
`endif
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         result_reg  <= '0;
         zero_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         result_reg  <= result_next;
         zero_reg    <= zero_next;
         illegal_reg <= illegal_next;
      end
   end

`ifndef CAYDE_ALU_BARREL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_reg <= '0;
         cnt_reg  <= '0;
         sop_reg  <= OP_SLL;
      end else begin
         work_reg <= work_next;
         cnt_reg  <= cnt_next;
         sop_reg  <= sop_next;
      end
   end
`endif

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.result    = result_reg;
   assign bus.zero      = zero_reg;
   assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_cayde_alu_exec.sv
// Scoreboard bench for cayde_alu_exec: expectations are queued on accept and
// popped when out_valid rises; latency, flags, hold and retirement are checked.
module tb_cayde_alu_exec;
   import cayde_alu_pkg::*;

   localparam int XLEN = 32;
`ifdef CAYDE_ALU_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cayde_alu_if #(.XLEN(XLEN)) bus_if ();

   cayde_alu_exec #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        illegal;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   sh;
      sh        = int'(b[4:0]);
      e.op      = op;
      e.a       = a;
      e.b       = b;
      e.illegal = 1'b0;
      e.lat     = 1;
      case (op)
         4'd0: e.res = a & b;
         4'd1: e.res = a | b;
         4'd2: e.res = a + b;
         4'd3: e.res = a ^ b;
         4'd4: e.res = a - b;
         4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: e.res = (a < b) ? 32'd1 : 32'd0;
         4'd7: e.res = a << sh;
         4'd8: e.res = a >> sh;
         4'd9: e.res = $unsigned($signed(a) >>> sh);
         default: begin
            e.res     = 32'd0;
            e.illegal = 1'b1;
         end
      endcase
      if (op >= 4'd7 && op <= 4'd9 && sh != 0 && !BARREL) e.lat = sh + 1;
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   // Queues the expectation and presents the request for exactly one edge.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      sb.push_back(model(op, a, b));
      @(negedge clk);
      bus_if.op       = op;
      bus_if.a        = a;
      bus_if.b        = b;
      bus_if.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
   endtask

   task automatic collect(input int hold);
      exp_t e;
      int   lat;
      bit   busy_ok;
      lat     = 1;
      busy_ok = 1'b1;
      while (!bus_if.out_valid && lat < 100) begin
         if (bus_if.in_ready) busy_ok = 1'b0;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
         return;
      end
      e = sb.pop_front();
      $display("[TB] op=%0d a=0x%08h b=0x%08h -> result=0x%08h zero=%0b illegal=%0b lat=%0d",
               e.op, e.a, e.b, bus_if.result, bus_if.zero, bus_if.illegal, lat);
      check_eq("out_valid", bus_if.out_valid, 1);
      check_eq("latency", lat, e.lat);
      check_eq("result", bus_if.result, e.res);
      check_eq("zero", bus_if.zero, e.zero);
      check_eq("illegal", bus_if.illegal, e.illegal);
      check_eq("in_ready_done", bus_if.in_ready, 0);
      if (e.lat > 1) check_eq("in_ready_shift", busy_ok, 1);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check_eq("hold_result", bus_if.result, e.res);
         check_eq("hold_valid", bus_if.out_valid, 1);
         check_eq("hold_in_ready", bus_if.in_ready, 0);
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check_eq("retire_valid", bus_if.out_valid, 0);
      check_eq("retire_in_ready", bus_if.in_ready, 1);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.op        = 4'd0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      rst_n            = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", bus_if.out_valid, 0);
      check_eq("rst_result", bus_if.result, 0);
      check_eq("rst_in_ready", bus_if.in_ready, 1);
      check_eq("rst_zero", bus_if.zero, 0);
      check_eq("rst_illegal", bus_if.illegal, 0);
      rst_n = 1'b1;

      send(4'd2, 32'd5, 32'd7);                   collect(0);
      send(4'd4, 32'd3, 32'd3);                   collect(0);
      send(4'd5, 32'hFFFF_FFFF, 32'd1);           collect(0);
      send(4'd6, 32'hFFFF_FFFF, 32'd1);           collect(0);
      send(4'd2, 32'hFFFF_FFFF, 32'd1);           collect(0);
      send(4'd9, 32'h8000_0000, 32'd4);           collect(0);
      send(4'd7, 32'd1, 32'd31);                  collect(10);
      send(4'd15, 32'h1234_5678, 32'h9);          collect(0);
      send(4'd0, 32'hF0, 32'h3C);                 collect(0);
      send(4'd9, 32'h8000_0000, 32'd31);          collect(0);
      send(4'd10, 32'd0, 32'd0);                  collect(0);
      send(4'd8, 32'hDEAD_BEEF, 32'hFFFF_FFE0);   collect(0);

      for (int i = 0; i < 16; i++) begin
         rop = 4'($urandom_range(0, 9));
         ra  = $urandom;
         rb  = $urandom;
         send(rop, ra, rb);
         collect(i % 3);
      end

      // Abort an SRL mid-flight; the queued expectation dies with the reset.
      send(4'd8, 32'hFFFF_FFFF, 32'd20);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      check_eq("abort_out_valid", bus_if.out_valid, 0);
      check_eq("abort_in_ready", bus_if.in_ready, 1);
      check_eq("abort_result", bus_if.result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'd3, 32'hFF, 32'h0F);                 collect(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
